// File: rtl/uart_burst_transmitter.sv
// Burst UART transmitter: one MSB-first sync frame followed by 1..128 LSB-first
// data frames pulled from a valid/ready byte source, with every bit held CLKS_PER_BIT clocks.
module uart_burst_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter logic [7:0]  SYNC_BYTE    = 8'h7E
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] burst_len,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned   TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TZERO = TW'(0);
    localparam logic [TW-1:0] TONE  = TW'(1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_SYNC_START = 4'd1,
        S_SYNC       = 4'd2,
        S_SYNC_STOP  = 4'd3,
        S_LOAD       = 4'd4,
        S_DATA_START = 4'd5,
        S_DATA       = 4'd6,
        S_DATA_STOP  = 4'd7,
        S_FIN        = 4'd8
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [6:0]    r_frames_left;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;
    logic          r_data_ready;

    state_t        w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [2:0]    w_bit_idx_nxt;
    logic [6:0]    w_frames_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_bit_end;
    logic          w_tx_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_ready_nxt;

    // Next-state logic: bit-timed states advance only when the bit timer wraps.
    always_comb begin
        w_bit_end     = (r_timer == TMAX);
        w_state_nxt   = r_state;
        w_timer_nxt   = w_bit_end ? TZERO : (r_timer + TONE);
        w_bit_idx_nxt = r_bit_idx;
        w_frames_nxt  = r_frames_left;
        w_shift_nxt   = r_shift;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = TZERO;
                if (start) begin
                    w_state_nxt  = S_SYNC_START;
                    w_frames_nxt = burst_len;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_SYNC_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_SYNC;
                    w_bit_idx_nxt = 3'd0;
                end else begin
                    w_state_nxt   = S_SYNC_START;
                end
            end
            S_SYNC: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt   = S_SYNC_STOP;
                end else if (w_bit_end) begin
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                end else begin
                    w_state_nxt   = S_SYNC;
                end
            end
            S_SYNC_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_SYNC_STOP;
                end
            end
            S_LOAD: begin
                // The line idles high here for as long as the source is starved.
                w_timer_nxt = TZERO;
                if (data_valid && r_data_ready) begin
                    w_shift_nxt = data_in;
                    w_state_nxt = S_DATA_START;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_DATA_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                end else begin
                    w_state_nxt   = S_DATA_START;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt   = S_DATA_STOP;
                end else if (w_bit_end) begin
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                end else begin
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA_STOP: begin
                if (w_bit_end && (r_frames_left == 7'd0)) begin
                    w_state_nxt  = S_FIN;
                end else if (w_bit_end) begin
                    w_frames_nxt = r_frames_left - 7'd1;
                    w_state_nxt  = S_LOAD;
                end else begin
                    w_state_nxt  = S_DATA_STOP;
                end
            end
            S_FIN: begin
                w_timer_nxt = TZERO;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_timer_nxt = TZERO;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop aligned with the state.
    always_comb begin
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE:       w_busy_nxt  = 1'b0;
            S_SYNC_START: w_tx_nxt    = 1'b0;
            S_SYNC:       w_tx_nxt    = SYNC_BYTE[3'd7 - w_bit_idx_nxt];
            S_SYNC_STOP:  w_tx_nxt    = 1'b1;
            S_LOAD:       w_ready_nxt = 1'b1;
            S_DATA_START: w_tx_nxt    = 1'b0;
            S_DATA:       w_tx_nxt    = w_shift_nxt[w_bit_idx_nxt];
            S_DATA_STOP:  w_tx_nxt    = 1'b1;
            S_FIN: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
            default:      w_busy_nxt  = 1'b0;
        endcase
    end

    // State, counters and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= TZERO;
            r_bit_idx     <= 3'd0;
            r_frames_left <= 7'd0;
            r_shift       <= 8'd0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_data_ready  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_frames_left <= w_frames_nxt;
            r_shift       <= w_shift_nxt;
            r_tx          <= w_tx_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_data_ready  <= w_ready_nxt;
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign data_ready = r_data_ready;

endmodule

// File: doc/uart_burst_transmitter.md
Name: uart_burst_transmitter

Overview:
Serial transmitter that produces the framed burst stream our UART receive path consumes. A burst is one sync frame followed by 1..128 data frames. The sync frame is a start bit plus 0x7E sent MSB-first, then a stop bit. Each data frame is a start bit, 8 data bits LSB-first, then a stop bit. The block sits between a byte-producing source (valid/ready) and the tx pin, and divides clk down to the bit rate.

Parameters:
CLKS_PER_BIT, 1, clk cycles each bit is held on tx (>=1); 1 gives one bit per clock, matching the receiver's sampling.
SYNC_BYTE, 8'h7E, sync pattern sent MSB-first after the sync start bit.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a burst; sampled only in IDLE
burst_len  input  7  data frames in burst minus 1 (0..127 means 1..128 frames); latched when start is accepted
data_in  input  8  byte to transmit
data_valid  input  1  data_in is valid
data_ready  output  1  block accepts data_in this cycle
tx  output  1  serial line; idle high
busy  output  1  high from start acceptance until burst complete
done  output  1  one-cycle pulse after the final stop bit

Behaviour:
- Reset (async, immediate, including mid-burst):
  - tx=1, busy=0, done=0, data_ready=0, state=IDLE.
  - Bit timer and frame counter cleared.
  - A partial frame is abandoned; the line simply returns high.
- All outputs are registered. Bit timer counts 0..CLKS_PER_BIT-1; a bit boundary occurs when it wraps.
- IDLE:
  - tx=1.
  - On start=1: latch burst_len into frames_left, set busy=1, drive tx=0 (sync start bit) from the next cycle, go to SYNC_START.
- SYNC_START: one bit time of 0, then go to SYNC.
- SYNC: 8 bit times carrying SYNC_BYTE[7] down to SYNC_BYTE[0], then go to SYNC_STOP.
- SYNC_STOP: one bit time of 1, then go to LOAD.
- LOAD:
  - tx=1, data_ready=1.
  - On data_valid&&data_ready: capture data_in and go to DATA_START, with data_ready=0 from the next cycle.
  - If data_valid stays low, hold here indefinitely with tx=1; the receiver tolerates idle high between frames.
- DATA_START: one bit time of 0.
- DATA: 8 bit times, bit0 first through bit7.
- DATA_STOP:
  - One bit time of 1.
  - If frames_left==0, go to FIN. Otherwise decrement frames_left and go to LOAD.
- FIN: for one cycle, done=1, busy=0, tx=1, then return to IDLE.
- Handshake: data_ready is asserted only in LOAD and is never high while busy=0. Bytes offered outside LOAD are ignored, not queued.
- start while busy=1 is ignored. start and data_valid asserted together in IDLE accepts only the start.
- Boundary and arithmetic rules:
  - burst_len=0 sends exactly 1 data frame.
  - burst_len=127 sends 128 frames, frames_left counting 127 down to 0 with no wrap.
  - Changes to burst_len mid-burst have no effect.
- Latency with CLKS_PER_BIT=1 and data_valid held high:
  - Sync frame occupies 10 cycles.
  - Each data frame occupies 11 cycles: 1 LOAD + 10 bits.
  - Total burst = 10 + 11*(burst_len+1) cycles, then done.
- Illegal or unused state encodings return to IDLE with tx=1.

Test Plan:
- CLKS_PER_BIT=1, burst_len=0, data_in=0xA5 always valid -> tx: 0, 0,1,1,1,1,1,1,0, 1, (LOAD 1), 0, 1,0,1,0,0,1,0,1, 1; done pulses 21 cycles after start; busy falls with done.
- CLKS_PER_BIT=4, burst_len=1, bytes 0x01 then 0x80 -> every bit held exactly 4 cycles; LSB-first data observed; exactly 2 data_ready handshakes; done asserted once.
- Starved source: burst_len=2, data_valid low 50 cycles before the second byte -> tx held 1 and data_ready held 1 throughout the gap; the frame then resumes intact; total handshakes = 3.
- burst_len=127 with incrementing bytes 0x00..0x7F -> 128 data frames, a loopback receiver reconstructs all bytes in order, then done.
- start pulsed again mid-burst and data_valid toggled outside LOAD -> no second burst and no extra byte consumed; the waveform is identical to an undisturbed run.
- rst_n asserted mid-DATA of frame 3 -> tx=1 and busy=0 immediately (asynchronous); after release, a new start produces a clean sync frame.
